// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM responder:
//   - state_e            : responder FSM states (IDLE, WAIT, RESP)
//   - BASE_ADDR_DEFAULT  : default byte address of word 0
//   - WORD_BYTES         : bytes per array word
//   - CNT_W              : latency counter width
//   - LFSR_SEED/LFSR_TAPS: 8-bit Fibonacci LFSR reset value and tap mask
//   - lfsr_next()        : one LFSR step
// -----------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8000_0000;
  localparam int unsigned WORD_BYTES        = 32'd4;
  localparam int unsigned CNT_W             = 32'd8;

  // Taps at stages 8,6,5,4 map to bits 7,5,4,3 of the register.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Shift left and feed the XOR of the tapped bits into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    logic fb;
    fb = ^(cur & LFSR_TAPS);
    return {cur[6:0], fb};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit Fibonacci LFSR used to jitter the responder latency. Only instantiated
// when SRAM_RESPONDER_RAND_DELAY_EN is defined.
//   clk   in  clock
//   rst   in  asynchronous active-high reset, reloads LFSR_SEED
//   step  in  advance the register by one step
//   value out current register contents
// -----------------------------------------------------------------------------
module lfsr8
  import sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  // Next value: advance only when stepped.
  always_comb begin
    value_d = value_q;
    if (step) begin
      value_d = lfsr_next(value_q);
    end else begin
      value_d = value_q;
    end
  end

  // LFSR state register, reseeded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= LFSR_SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
// Handshaked, fixed-latency word SRAM responder for the core's IFU/LSU bus.
// One request in flight; read or byte-masked write performed LATENCY cycles
// after acceptance; the response is held until the initiator takes it.
// Writes return the word value before the write. Out-of-range accesses return
// rsp_err = 1 with zero data and leave the array untouched.
//
// Optional: define SRAM_RESPONDER_RAND_DELAY_EN to add 0..3 extra cycles of
// latency drawn from an 8-bit LFSR that advances once per accepted request.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE, low in reset)
//   req_wen                  1 = write, 0 = read
//   req_addr                 byte address, bits [1:0] ignored
//   req_wdata, req_wmask     write data and byte-lane enables
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata                read data, or pre-write value for writes
//   rsp_err                  address outside the mapped window
// -----------------------------------------------------------------------------
module sram_responder
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned DEPTH_WORDS = 32'd4096,
  parameter int unsigned LATENCY     = 32'd2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 32'd1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wen_q, wen_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             accept_s;
  logic             access_s;
  logic [CNT_W-1:0] extra_s;
  logic [31:0]      off_s;
  logic [31:0]      word_idx_s;
  logic             in_range_s;
  logic [AW-1:0]    idx_s;

  logic [31:0]      mem [DEPTH_WORDS];

  assign accept_s = req_valid && (state_q == IDLE);

`ifdef SRAM_RESPONDER_RAND_DELAY_EN
  logic [7:0] lfsr_value_s;

  lfsr8 u_lfsr8 (
    .clk   (clk),
    .rst   (rst),
    .step  (accept_s),
    .value (lfsr_value_s)
  );

  assign extra_s = {{(CNT_W-2){1'b0}}, lfsr_value_s[1:0]};
`else
  assign extra_s = {CNT_W{1'b0}};
`endif

  // Word index is taken modulo 2^32 so addresses below the base wrap high
  // and land out of range.
  assign off_s      = addr_q - BASE_ADDR;
  assign word_idx_s = off_s / WORD_BYTES;
  assign in_range_s = (word_idx_s < DEPTH_WORDS);
  assign idx_s      = word_idx_s[AW-1:0];

  // FSM next state, request latch and access strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    access_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          cnt_d   = CNT_LOAD + extra_s;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          access_s = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response data: captured at the access edge, held until the next access.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (access_s) begin
      if (in_range_s) begin
        rdata_d = mem[idx_s];
        err_d   = 1'b0;
      end else begin
        rdata_d = 32'h0000_0000;
        err_d   = 1'b1;
      end
    end else begin
      rdata_d = rdata_q;
      err_d   = err_q;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      wen_q   <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      wmask_q <= 4'h0;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array: not reset; lanes written on the same edge as the read.
  always_ff @(posedge clk) begin
    if (access_s && wen_q && in_range_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) begin
          mem[idx_s][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder with a word-level memory model.
module tb_sram_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 4096;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wmask = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_mem [int unsigned];

  sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference: word index from byte offset, lane-wise merge for writes.
  task automatic model_access(input logic wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wmask,
                              output logic [31:0] rdata, output logic err);
    int unsigned idx;
    logic [31:0] nw;
    idx = (addr - BASE) / 4;
    if (idx < DEPTH) begin
      err   = 1'b0;
      rdata = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      if (wen) begin
        nw = rdata;
        for (int b = 0; b < 4; b++)
          if (wmask[b]) nw[8*b +: 8] = wdata[8*b +: 8];
        model_mem[idx] = nw;
      end
    end else begin
      err   = 1'b1;
      rdata = 32'h0;
    end
  endtask

  task automatic do_txn(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input string name, output int lat);
    logic [31:0] exp_rdata;
    logic exp_err;
    int g;
    model_access(wen, addr, wdata, wmask, exp_rdata, exp_err);
    @(negedge clk);
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    vectors++;
    if (g >= 20) begin
      miscompares++;
      $display("FAIL %s accept_timeout req_ready=%b required 1", name, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s early_rsp rsp_valid=%b required 0", name, rsp_valid);
    end
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    vectors++;
`ifdef SRAM_RESPONDER_RAND_DELAY_EN
    if (lat < LAT || lat > LAT + 3) begin
      miscompares++;
      $display("FAIL %s latency got=%0d required %0d..%0d", name, lat, LAT, LAT + 3);
    end
`else
    if (lat != LAT) begin
      miscompares++;
      $display("FAIL %s latency got=%0d required %0d", name, lat, LAT);
    end
`endif
    vectors++;
    if (rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
      miscompares++;
      $display("FAIL %s data rdata=%h err=%b required rdata=%h err=%b",
               name, rsp_rdata, rsp_err, exp_rdata, exp_err);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s after_handshake rsp_valid=%b req_ready=%b required 0/1",
               name, rsp_valid, req_ready);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_active ready=%b valid=%b rdata=%h err=%b required 0/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk); rst = 1'b0; #1;
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release ready=%b valid=%b required 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_directed();
    int lat;
    do_txn(1'b1, 32'h8000_0000, 32'hCAFE_0001, 4'hF, "init_word0", lat);
    do_txn(1'b1, 32'h8000_0010, 32'h1122_3344, 4'hF, "write_full", lat);
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, "read_back", lat);
    do_txn(1'b1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, "write_lane1", lat);
    do_txn(1'b0, 32'h8000_0012, 32'h0, 4'h0, "read_merged", lat);
    do_txn(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, "write_nomask", lat);
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, "read_nomask", lat);
    do_txn(1'b1, 32'h7FFF_FFFC, 32'h5555_AAAA, 4'hF, "oor_low_write", lat);
    do_txn(1'b1, 32'h8000_4000, 32'h5555_AAAA, 4'hF, "oor_high_write", lat);
    do_txn(1'b0, 32'h8000_4000, 32'h0, 4'h0, "oor_high_read", lat);
    do_txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, "word0_intact", lat);
    do_txn(1'b1, 32'h8000_3FFC, 32'h0BAD_CAFE, 4'hF, "last_word_write", lat);
    do_txn(1'b0, 32'h8000_3FFC, 32'h0, 4'h0, "last_word_read", lat);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a, exp_b;
    logic err_a, err_b;
    int g;
    model_access(1'b0, 32'h8000_0010, 32'h0, 4'h0, exp_a, err_a);
    model_access(1'b0, 32'h8000_0000, 32'h0, 4'h0, exp_b, err_b);
    @(negedge clk);
    req_wen = 1'b0; req_addr = 32'h8000_0010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    g = 0;
    while (rsp_valid !== 1'b1 && g < 20) begin @(posedge clk); #1; g++; end
    @(negedge clk);
    req_addr = 32'h8000_0000; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_a || rsp_err !== err_a || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d valid=%b rdata=%h err=%b ready=%b required 1/%h/%b/0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, exp_a, err_a);
      end
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_bubble valid=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept ready=%b required 0", req_ready);
    end
    g = 0;
    while (rsp_valid !== 1'b1 && g < 20) begin @(posedge clk); #1; g++; end
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_b || rsp_err !== err_b) begin
      miscompares++;
      $display("FAIL bp_second valid=%b rdata=%h err=%b required 1/%h/%b",
               rsp_valid, rsp_rdata, rsp_err, exp_b, err_b);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_flight();
    int lat;
    do_txn(1'b1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, "rif_prior", lat);
    @(negedge clk);
    req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'hDEAD_BEEF;
    req_wmask = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rif_reset ready=%b valid=%b rdata=%h err=%b required 0/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rif_no_rsp%0d rsp_valid=%b required 0", i, rsp_valid);
      end
    end
    do_txn(1'b0, 32'h8000_0020, 32'h0, 4'h0, "rif_readback", lat);
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    logic [31:0] addr;
    int lat;
    for (int i = 0; i < 8; i++) pool[i] = BASE + 32'(($urandom % DEPTH) * 4);
    pool[0] = 32'h8000_3FFC;
    for (int i = 0; i < 8; i++)
      do_txn(1'b1, pool[i], $urandom, 4'hF, "rnd_init", lat);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) addr = BASE - 32'd4 - ($urandom & 32'h0000_FFF0);
        else addr = BASE + 32'h0000_4000 + ($urandom & 32'h00FF_FFF0);
      end else begin
        addr = pool[$urandom_range(0, 7)] | ($urandom & 32'h3);
      end
      do_txn(1'($urandom), addr, $urandom, 4'($urandom), "rnd_txn", lat);
    end
  endtask

`ifdef SRAM_RESPONDER_RAND_DELAY_EN
  task automatic test_rand_delay();
    int seq_a [16];
    int seq_b [16];
    apply_reset();
    for (int i = 0; i < 16; i++) do_txn(1'b0, BASE, 32'h0, 4'h0, "rd_seq_a", seq_a[i]);
    apply_reset();
    for (int i = 0; i < 16; i++) do_txn(1'b0, BASE, 32'h0, 4'h0, "rd_seq_b", seq_b[i]);
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (seq_a[i] != seq_b[i]) begin
        miscompares++;
        $display("FAIL rd_repeat%0d latency=%0d required %0d", i, seq_b[i], seq_a[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_in_flight();
    test_random();
`ifdef SRAM_RESPONDER_RAND_DELAY_EN
    test_rand_delay();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the core's load/store and instruction-fetch requests.
- Replaces the zero-latency combinational memory model with a handshaked, fixed-latency word SRAM.
- Accepts one request at a time and performs a read or a byte-masked write after a programmable delay.
- Holds the response until the initiator takes it.
- Sits between the core's bus initiator (IFU/LSU side) and the backing storage array.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0.
- DEPTH_WORDS, 4096, number of 32-bit words in the array. Must be a power of two.
- LATENCY, 2, cycles from request acceptance to rsp_valid. Must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; bits [1:0] ignored (word access).
- req_wdata  in  32  write data, byte lanes aligned to the word.
- req_wmask  in  4  byte-lane write enables; bit i enables byte lane [8i+7:8i].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  read data. For writes: the word value before the write.
- rsp_err  out  1  address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).

Behaviour:
- Reset (async, rst = 1):
  - State goes to IDLE; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
  - req_ready = 0 while rst is high.
  - Array contents are not reset.
- State machine:
  - IDLE: req_ready = 1. On req_valid & req_ready, latch addr, wen, wdata and wmask; load counter with LATENCY-1; go to WAIT. No other state asserts req_ready.
  - WAIT: if counter == 0, perform the access and go to RESP; else decrement the counter.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready; on that handshake go to IDLE and drop rsp_valid.
- Latency: request accepted at edge N gives rsp_valid high after edge N+LATENCY.
- Throughput:
  - Minimum one-cycle IDLE bubble between the response handshake and the next acceptance.
  - Peak throughput is one request per LATENCY+2 cycles.
- Access rules:
  - Index = (req_addr - BASE_ADDR) >> 2, computed modulo 2^32.
  - In range (index < DEPTH_WORDS):
    - rsp_rdata = array[index].
    - Writes update only the lanes with wmask bit set, in the same edge.
    - A write with wmask = 0 is a no-op that still responds.
  - Out of range: rsp_err = 1, rsp_rdata = 0, no array update.
- Request-side inputs are ignored outside IDLE. A held req_valid is accepted only on return to IDLE.
- Asserting rst during WAIT or RESP:
  - The in-flight request is dropped.
  - No write is committed unless the access edge already occurred.
  - No response is produced.

Optional Feature:
- Macro: SRAM_RESPONDER_RAND_DELAY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances once per accepted request.
  - The counter is loaded with LATENCY-1 + lfsr[1:0], so latency ranges over LATENCY..LATENCY+3.
- Undefined: fixed LATENCY; no LFSR logic is instantiated.

Decomposition:
- Shared package (sram_pkg):
  - State enum {IDLE, WAIT, RESP}.
  - Constants BASE_ADDR default 32'h8000_0000 and WORD_BYTES = 4.
  - LFSR seed and tap constants.
- Sub-module lfsr8, instantiated only under SRAM_RESPONDER_RAND_DELAY_EN.
  - Ports: clk, rst, step, value[7:0].

Test Plan:
- Reset: assert rst mid-cycle, deassert → rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, req_ready = 0 during rst, then 1.
- Write/read round trip (LATENCY = 2):
  - Write 0x11223344, mask 4'hF, to 0x8000_0010 → rsp_valid 2 cycles after acceptance, rsp_err = 0.
  - Read of 0x8000_0010 → 0x11223344.
- Byte-masked write:
  - Write 0x0000AB00, mask 4'b0010, over 0x11223344 → rsp_rdata = 0x11223344 (old value).
  - Subsequent read → 0x1122AB44.
- Out-of-range accesses:
  - Write to 0x7FFF_FFFC → rsp_err = 1, rsp_rdata = 0.
  - Read at 0x8000_4000 (DEPTH_WORDS = 4096) → rsp_err = 1; word 0 is unchanged.
- Backpressure:
  - Hold rsp_ready = 0 for 5 cycles after rsp_valid → rsp_valid and rsp_rdata stable, req_ready = 0 throughout.
  - A new req_valid is accepted only after the handshake plus a one-cycle IDLE.
- Reset in flight:
  - Assert rst one cycle into WAIT of a write of 0xDEADBEEF to 0x8000_0020 → no response.
  - Later read returns the prior contents.
  - With SRAM_RESPONDER_RAND_DELAY_EN, 16 reads show latency within 2..5 and the same sequence after each reset.
